bcd_to_binary_seq: RTL and testbench

Iterative BCD-to-binary converter using reverse double dabble: shift right one bit per cycle, then subtract 3 from every BCD digit that reads 8 or more. It is the inverse path of the taxi display's binary-to-BCD converter. It turns keypad or fare-entry BCD values (up to 4 digits) back into binary for the fare and distance arithmetic. A start/busy/done handshake lets the control FSM launch one conversion at a time.

---
 rtl/bcd_pkg.sv | 17 +
 rtl/bcd_to_binary_seq_if.sv | 27 ++
 rtl/bcd_digit_adjust.sv | 14 +
 rtl/bcd_to_binary_seq.sv | 98 +++++++++
 tb/tb_bcd_to_binary_seq.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/bcd_pkg.sv
// Shared constants and types for the BCD-to-binary converter.
// Optional macro BCD_CHECK_EN enables invalid-digit rejection in the top.
package bcd_pkg;

  localparam int BCD_DIGIT_W = 4;
  localparam int BCD_DIGITS  = 4;
  localparam int BCD_BIN_W   = 14;

  localparam logic [3:0] BCD_ADJ_THRESH = 4'd8;
  localparam logic [3:0] BCD_ADJ_VAL    = 4'd3;

  typedef enum logic {
    IDLE,
    SHIFT
  } bcd2bin_state_t;

endpackage

// File: rtl/bcd_to_binary_seq_if.sv
// Start/busy/done handshake bundle for the BCD-to-binary converter.
// Width follows DIGITS/BIN_W; BCD_CHECK_EN affects only the top.
interface bcd_to_binary_seq_if
  import bcd_pkg::*;
#(
  parameter int DIGITS = BCD_DIGITS,
  parameter int BIN_W  = BCD_BIN_W
) ();

  logic                          start;
  logic [BCD_DIGIT_W*DIGITS-1:0] bcd_in;
  logic                          busy;
  logic                          done;
  logic [BIN_W-1:0]              bin_out;
  logic                          err;

  modport master (
    output start, bcd_in,
    input  busy, done, bin_out, err
  );

  modport slave (
    input  start, bcd_in,
    output busy, done, bin_out, err
  );

endinterface

// File: rtl/bcd_digit_adjust.sv
// One BCD digit correction step of reverse double dabble.
// Not affected by BCD_CHECK_EN.
module bcd_digit_adjust
  import bcd_pkg::*;
(
  input  logic [3:0] d_i,
  output logic [3:0] d_o
);

  assign d_o = (d_i >= BCD_ADJ_THRESH)
             ? d_i - BCD_ADJ_VAL
             : d_i;

endmodule

// File: rtl/bcd_to_binary_seq.sv
// Iterative BCD-to-binary converter, one shift per clock.
// Define BCD_CHECK_EN to reject inputs holding digits above 9.
module bcd_to_binary_seq
  import bcd_pkg::*;
#(
  parameter int DIGITS = BCD_DIGITS,
  parameter int BIN_W  = BCD_BIN_W
) (
  input logic clk,
  input logic rst,
  bcd_to_binary_seq_if.slave io
);

  localparam int BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int SR_W  = BCD_W + BIN_W;
  localparam int CNT_W = $clog2(BIN_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BIN_W - 1);

  bcd2bin_state_t    state_q;
  logic [SR_W-1:0]   sr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic [BIN_W-1:0]  bin_q;

  logic [SR_W-1:0]   shr;
  logic [SR_W-1:0]   sr_d;
  logic              reject;

  assign shr = sr_q >> 1;
  assign sr_d[BIN_W-1:0] = shr[BIN_W-1:0];

  // Digit fields sit above the binary accumulator.
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .d_i (shr[BIN_W+BCD_DIGIT_W*g +: BCD_DIGIT_W]),
      .d_o (sr_d[BIN_W+BCD_DIGIT_W*g +: BCD_DIGIT_W])
    );
  end

`ifdef BCD_CHECK_EN
  always_comb begin
    reject = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (io.bcd_in[BCD_DIGIT_W*i +: BCD_DIGIT_W] > 4'd9)
        reject = 1'b1;
    end
  end
`else
  assign reject = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      bin_q   <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (io.start && reject) begin
            bin_q  <= '0;
            err_q  <= 1'b1;
            done_q <= 1'b1;
          end else if (io.start) begin
            sr_q    <= {io.bcd_in, {BIN_W{1'b0}}};
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          sr_q  <= sr_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            bin_q   <= sr_d[BIN_W-1:0];
            done_q  <= 1'b1;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign io.busy    = busy_q;
  assign io.done    = done_q;
  assign io.err     = err_q;
  assign io.bin_out = bin_q;

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Self-checking bench for bcd_to_binary_seq (vector table + random).
// Extra checks run when BCD_CHECK_EN is defined.
module tb_bcd_to_binary_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;

  bcd_to_binary_seq_if #(.DIGITS(4), .BIN_W(14)) bus ();

  bcd_to_binary_seq #(.DIGITS(4), .BIN_W(14)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [15:0] bcd;
    int          exp;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int bcd_ref(input logic [15:0] b);
    int v = 0;
    for (int i = 3; i >= 0; i--)
      v = v * 10 + int'(b[4*i +: 4]);
    return v;
  endfunction

  // Returns at #1 after the accepting edge.
  task automatic launch(input logic [15:0] b);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.bcd_in = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int bcnt);
    lat  = 0;
    bcnt = int'(bus.busy);
    while (!bus.done && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      bcnt += int'(bus.busy);
    end
  endtask

  task automatic run_one(input logic [15:0] b, input int exp);
    int lat, bcnt;
    launch(b);
    wait_done(lat, bcnt);
    chk($sformatf("lat_%h", b), lat, 14);
    chk($sformatf("busy_%h", b), bcnt, 14);
    chk($sformatf("bin_%h", b), int'(bus.bin_out), exp);
    chk($sformatf("err_%h", b), int'(bus.err), 0);
    @(posedge clk);
    #1;
    chk($sformatf("pulse_%h", b), int'(bus.done), 0);
  endtask

  initial begin
    int lat, bcnt, dcnt, first, held;
    logic [15:0] r;

    vecs[0] = '{16'h0000, 0};
    vecs[1] = '{16'h9999, 9999};
    vecs[2] = '{16'h0255, 255};
    vecs[3] = '{16'h1024, 1024};
    vecs[4] = '{16'h0001, 1};
    vecs[5] = '{16'h5000, 5000};
    vecs[6] = '{16'h0099, 99};
    vecs[7] = '{16'h8080, 8080};

    bus.start  = 1'b0;
    bus.bcd_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_bin", int'(bus.bin_out), 0);
    chk("rst_err", int'(bus.err), 0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) run_one(vecs[i].bcd, vecs[i].exp);

    for (int i = 0; i < 20; i++) begin
      r = '0;
      for (int d = 0; d < 4; d++)
        r[4*d +: 4] = 4'($urandom_range(0, 9));
      run_one(r, bcd_ref(r));
    end

    // Back-to-back: start held through the done cycle.
    launch(16'h0255);
    wait_done(lat, bcnt);
    chk("b2b_lat1", lat, 14);
    chk("b2b_bin1", int'(bus.bin_out), 255);
    bus.start  = 1'b1;
    bus.bcd_in = 16'h1024;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk("b2b_acc_busy", int'(bus.busy), 1);
    chk("b2b_acc_done", int'(bus.done), 0);
    wait_done(lat, bcnt);
    chk("b2b_lat2", lat, 14);
    chk("b2b_bin2", int'(bus.bin_out), 1024);

    // Start during a conversion must be ignored.
    launch(16'h0007);
    dcnt  = 0;
    first = 0;
    held  = -1;
    for (int k = 1; k <= 30; k++) begin
      if (k == 5) begin
        bus.start  = 1'b1;
        bus.bcd_in = 16'h0042;
      end
      @(posedge clk);
      #1;
      if (k == 5) bus.start = 1'b0;
      if (bus.done) begin
        dcnt++;
        if (first == 0) first = k;
        held = int'(bus.bin_out);
      end
    end
    chk("ign_dones", dcnt, 1);
    chk("ign_lat", first, 14);
    chk("ign_bin", held, 7);
    chk("ign_busy", int'(bus.busy), 0);

    // Asynchronous reset in the middle of a conversion.
    launch(16'h5678);
    repeat (7) @(posedge clk);
    #1;
    chk("mid_busy_pre", int'(bus.busy), 1);
    rst = 1'b1;
    #1;
    chk("mid_busy", int'(bus.busy), 0);
    chk("mid_done", int'(bus.done), 0);
    chk("mid_bin", int'(bus.bin_out), 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    run_one(16'h0013, 13);

`ifdef BCD_CHECK_EN
    launch(16'h12A4);
    chk("inv_done", int'(bus.done), 1);
    chk("inv_err", int'(bus.err), 1);
    chk("inv_bin", int'(bus.bin_out), 0);
    chk("inv_busy", int'(bus.busy), 0);
    @(posedge clk);
    #1;
    chk("inv_pulse", int'(bus.done), 0);
    chk("inv_busy2", int'(bus.busy), 0);
    launch(16'h0001);
    wait_done(lat, bcnt);
    chk("inv_next_lat", lat, 14);
    chk("inv_next_err", int'(bus.err), 0);
    chk("inv_next_bin", int'(bus.bin_out), 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
